dot_product_accumulator: RTL and testbench

- Downstream consumer of the 2-stage shift-and-add multiply unit. It takes that unit's product/done pair and sums a programmed number of products into one dot-product result.
- It presents the finished sum to the vector-multiplier control/output logic through a valid/ready handshake and holds it until accepted.
- Sits between the multiply unit and the top-level result register of the dense vector-vector multiplier.

---
 rtl/dvm_pkg.sv | 18 +
 rtl/dot_product_accumulator.sv | 160 ++++++++++++++++
 tb/tb_dot_product_accumulator.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dvm_pkg.sv
// Shared definitions for the dense vector-vector multiplier datapath.
//   - dvm_state_e : control state of the dot-product accumulator
//   - DVM_*       : default widths; DVM_MUL_PROD_W is the product width
//                   produced by the 2-stage shift-and-add multiply unit.
package dvm_pkg;

    localparam int unsigned DVM_MUL_PROD_W = 16;
    localparam int unsigned DVM_PROD_W     = DVM_MUL_PROD_W;
    localparam int unsigned DVM_LEN_W      = 8;
    localparam int unsigned DVM_ACC_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } dvm_state_e;

endpackage

// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator
// Sums vec_len products from the multiply unit into one dot-product result
// and presents it through a valid/ready handshake, held until accepted.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   start        begin a new operation (honoured only in IDLE)
//   vec_len      number of products to sum, latched on accepted start
//   prod_in      product from the multiply unit
//   prod_valid   product qualifier (multiply unit done)
//   busy         high whenever not IDLE
//   count        products accumulated in the current operation
//   dot_out      final sum, stable while dot_valid
//   dot_valid    result available
//   dot_ready    downstream accepts result
//   overflow     sticky carry out of the accumulator for this operation
//   err_drop     sticky: product arrived outside ACCUM and was discarded
//
// Build option: define ACC_SAT_EN to saturate the accumulator at all-ones
// instead of wrapping modulo 2^ACC_W.
module dot_product_accumulator
    import dvm_pkg::*;
#(
    parameter int unsigned PROD_W = DVM_PROD_W,
    parameter int unsigned LEN_W  = DVM_LEN_W,
    parameter int unsigned ACC_W  = DVM_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              busy,
    output logic [LEN_W-1:0]  count,
    output logic [ACC_W-1:0]  dot_out,
    output logic              dot_valid,
    input  logic              dot_ready,
    output logic              overflow,
    output logic              err_drop
);

    dvm_state_e         state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   dot_out_q, dot_out_d;
    logic               dot_valid_q, dot_valid_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    logic [ACC_W:0]     sum_ext;
    logic               carry;
    logic [ACC_W-1:0]   acc_next;
    logic [LEN_W-1:0]   count_inc;

    // One extra bit on the adder captures the carry out of bit ACC_W-1.
    assign sum_ext   = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};
    assign carry     = sum_ext[ACC_W];
    assign count_inc = count_q + LEN_W'(1);

`ifdef ACC_SAT_EN
    // All-ones plus any nonzero product carries again, so a saturated
    // accumulator stays pinned at all-ones.
    assign acc_next = carry ? '1 : sum_ext[ACC_W-1:0];
`else
    assign acc_next = sum_ext[ACC_W-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        len_d       = len_q;
        count_d     = count_q;
        dot_out_d   = dot_out_q;
        dot_valid_d = dot_valid_q;
        ovf_d       = ovf_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (prod_valid) begin
                    err_d = 1'b1;
                end
                // An accepted start clears the sticky flags, even if a stray
                // product arrives in the same cycle.
                if (start) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    if (vec_len != '0) begin
                        len_d   = vec_len;
                        state_d = ACCUM;
                    end else begin
                        dot_out_d   = '0;
                        dot_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            ACCUM: begin
                if (prod_valid) begin
                    acc_d   = acc_next;
                    count_d = count_inc;
                    if (carry) begin
                        ovf_d = 1'b1;
                    end
                    if (count_inc == len_q) begin
                        dot_out_d   = acc_next;
                        dot_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (prod_valid) begin
                    err_d = 1'b1;
                end
                if (dot_ready) begin
                    dot_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            len_q       <= '0;
            count_q     <= '0;
            dot_out_q   <= '0;
            dot_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            count_q     <= count_d;
            dot_out_q   <= dot_out_d;
            dot_valid_q <= dot_valid_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign count     = count_q;
    assign dot_out   = dot_out_q;
    assign dot_valid = dot_valid_q;
    assign overflow  = ovf_q;
    assign err_drop  = err_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Testbench for dot_product_accumulator: a default-width instance (ACC_W=32)
// and a narrow instance (ACC_W=16) see identical stimulus; expected sums and
// overflow flags come from a plain-arithmetic reference over the product list.
module tb_dot_product_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  vec_len = '0;
    logic [15:0] prod_in = '0;
    logic        prod_valid = 1'b0;
    logic        dot_ready = 1'b0;

    logic        a_busy, a_dot_valid, a_overflow, a_err_drop;
    logic [7:0]  a_count;
    logic [31:0] a_dot_out;
    logic        b_busy, b_dot_valid, b_overflow, b_err_drop;
    logic [7:0]  b_count;
    logic [15:0] b_dot_out;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [15:0] pq[$];
    logic [63:0] exp_a, exp_b;
    bit          ovf_a, ovf_b;

    always #5 clk = ~clk;

    dot_product_accumulator dut_a (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
        .prod_in(prod_in), .prod_valid(prod_valid), .busy(a_busy),
        .count(a_count), .dot_out(a_dot_out), .dot_valid(a_dot_valid),
        .dot_ready(dot_ready), .overflow(a_overflow), .err_drop(a_err_drop)
    );

    dot_product_accumulator #(.ACC_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
        .prod_in(prod_in), .prod_valid(prod_valid), .busy(b_busy),
        .count(b_count), .dot_out(b_dot_out), .dot_valid(b_dot_valid),
        .dot_ready(dot_ready), .overflow(b_overflow), .err_drop(b_err_drop)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Reference: running sum of the product list at width w.
    function automatic void ref_sum(input int unsigned w, output logic [63:0] s, output bit ov);
        logic [63:0] lim;
        logic [63:0] t;
        lim = (64'd1 << w) - 64'd1;
        s   = '0;
        ov  = 1'b0;
        foreach (pq[i]) begin
            t = s + 64'(pq[i]);
            if (t > lim) begin
                ov = 1'b1;
`ifdef ACC_SAT_EN
                t = lim;
`else
                t = t & lim;
`endif
            end
            s = t;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation over the current contents of pq.
    task automatic do_op(input int gmin, input int gmax);
        int len;
        len = pq.size();
        ref_sum(32, exp_a, ovf_a);
        ref_sum(16, exp_b, ovf_b);
        start   = 1'b1;
        vec_len = 8'(len);
        step();
        start = 1'b0;
        check("busy_after_start", a_busy, 1'b1);
        check("err_cleared", a_err_drop, 1'b0);
        if (len == 0) begin
            check("zero_len_valid", a_dot_valid, 1'b1);
            check("zero_len_out", a_dot_out, 0);
            check("zero_len_out16", b_dot_out, 0);
            check("zero_len_ovf", a_overflow, 1'b0);
        end
        for (int i = 0; i < len; i++) begin
            int gaps;
            gaps = $urandom_range(gmax, gmin);
            for (int g = 0; g < gaps; g++) begin
                step();
                check("gap_busy", a_busy, 1'b1);
                check("gap_count", a_count, 64'(i));
            end
            prod_valid = 1'b1;
            prod_in    = pq[i];
            step();
            prod_valid = 1'b0;
            check("count", a_count, 64'(i + 1));
            if (i < len - 1) begin
                check("not_valid_yet", a_dot_valid, 1'b0);
            end else begin
                check("dot_valid", a_dot_valid, 1'b1);
                check("dot_valid16", b_dot_valid, 1'b1);
                check("dot_out", a_dot_out, exp_a);
                check("dot_out16", b_dot_out, exp_b);
                check("overflow", a_overflow, 64'(ovf_a));
                check("overflow16", b_overflow, 64'(ovf_b));
            end
        end
    endtask

    // Holds the result for n cycles (optionally with stray products), then accepts it.
    task automatic release_result(input int n, input bit junk);
        for (int i = 0; i < n; i++) begin
            dot_ready  = 1'b0;
            prod_valid = junk;
            prod_in    = 16'd100;
            step();
            prod_valid = 1'b0;
            check("hold_valid", a_dot_valid, 1'b1);
            check("hold_out", a_dot_out, exp_a);
            check("hold_out16", b_dot_out, exp_b);
            check("hold_count", a_count, 64'(pq.size()));
        end
        if (junk && n > 0) begin
            check("err_drop", a_err_drop, 1'b1);
        end
        dot_ready = 1'b1;
        step();
        dot_ready = 1'b0;
        check("accept_valid", a_dot_valid, 1'b0);
        check("accept_busy", a_busy, 1'b0);
        check("accept_keep_out", a_dot_out, exp_a);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", a_busy, 1'b0);
        check("rst_valid", a_dot_valid, 1'b0);
        check("rst_out", a_dot_out, 0);
        check("rst_count", a_count, 0);
        check("rst_flags", {a_overflow, a_err_drop}, 0);
        rst = 1'b0;
        step();

        // Back-to-back products, then backpressure with stray products and ignored start.
        pq = '{16'd3, 16'd5, 16'd7, 16'd9};
        do_op(0, 0);
        check("sum24", a_dot_out, 64'd24);
        release_result(5, 1'b1);
        pq = '{16'd3, 16'd5, 16'd7, 16'd9};
        do_op(0, 0);
        start = 1'b1;
        step();
        check("start_in_hold_ignored", a_dot_valid, 1'b1);
        dot_ready = 1'b1;
        step();
        start = 1'b0;
        dot_ready = 1'b0;
        check("start_with_accept_ignored", a_busy, 1'b0);
        step();
        check("still_idle", a_busy, 1'b0);

        // Gapped products.
        pq = '{16'd10, 16'd20, 16'd30};
        do_op(2, 2);
        check("sum60", a_dot_out, 64'd60);
        release_result(1, 1'b0);

        // Zero-length operation.
        pq = {};
        exp_a = '0;
        exp_b = '0;
        do_op(0, 0);
        release_result(0, 1'b0);

        // Carry out of the 16-bit accumulator.
        pq = '{16'hFFFF, 16'h0002};
        do_op(0, 0);
`ifdef ACC_SAT_EN
        check("ovf16_out", b_dot_out, 64'hFFFF);
`else
        check("ovf16_out", b_dot_out, 64'h0001);
`endif
        check("ovf16_flag", b_overflow, 1'b1);
        check("ovf32_out", a_dot_out, 64'h10001);
        release_result(1, 1'b0);

        // Reset in the middle of an operation.
        start   = 1'b1;
        vec_len = 8'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1;
            prod_in    = 16'd50;
            step();
        end
        prod_valid = 1'b0;
        rst = 1'b1;
        #2;
        check("midrst_busy", a_busy, 1'b0);
        check("midrst_count", a_count, 0);
        check("midrst_out", {a_dot_valid, a_dot_out}, 0);
        step();
        rst = 1'b0;
        step();
        pq = '{16'd7};
        do_op(0, 0);
        check("after_rst_sum", a_dot_out, 64'd7);
        release_result(1, 1'b0);

        // Randomised operations.
        for (int op = 0; op < 12; op++) begin
            int len;
            len = $urandom_range(6, 1);
            pq = {};
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(3, 0) == 0) pq.push_back(16'($urandom_range(16'hFFFF, 16'hF000)));
                else pq.push_back(16'($urandom_range(255, 0)));
            end
            do_op(0, 2);
            release_result($urandom_range(3, 0), 1'($urandom_range(1, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
